fetch_wait_state_adapter: RTL and testbench

- Sits between the core instruction-fetch port and the always-granting RAM port b, replacing the hard-wired `instr_gnt = instr_req`.
- Injects a programmable grant latency and a programmable response latency so fetch-stall paths in the prefetch buffer get exercised.
- Bounds outstanding fetches and returns responses in order through a small timestamped response FIFO.

---
 rtl/fetch_wait_pkg.sv | 30 +++
 rtl/fetch_wait_state_adapter_rsp_stamp_fifo.sv | 70 +++++++
 rtl/fetch_wait_state_adapter.sv | 189 ++++++++++++++++++
 tb/tb_fetch_wait_state_adapter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_wait_pkg.sv
// Shared types for the fetch wait-state adapter.
//   fetch_state_e : grant-side FSM states
//   stamp_t       : free-running timestamp used to age queued responses
//   rsp_entry_t   : one queued device response {rdata, err, stamp}
package fetch_wait_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

    localparam int unsigned StampWidth   = 5;
    localparam int unsigned RspDataWidth = 32;

    typedef logic [StampWidth-1:0] stamp_t;

    typedef struct packed {
        logic [RspDataWidth-1:0] rdata;
        logic                    err;
        stamp_t                  stamp;
    } rsp_entry_t;

    // Age of an entry relative to the running stamp. Modulo arithmetic is
    // safe because no entry can sit in the queue for 2**StampWidth cycles.
    function automatic stamp_t stamp_age(stamp_t now, stamp_t stamp);
        return now - stamp;
    endfunction

endpackage

// File: rtl/fetch_wait_state_adapter_rsp_stamp_fifo.sv
// In-order response queue holding timestamped device responses.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i         : write push_entry_i at the tail
//   pop_i          : drop the head entry (parent decides when it has aged)
//   head_o         : oldest entry, valid when empty_o=0
//   full_o/empty_o : occupancy flags
module rsp_stamp_fifo
    import fetch_wait_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  rsp_entry_t push_entry_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = PtrWidth + 1;

    rsp_entry_t          mem_q [Depth];
    rsp_entry_t          mem_d [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PtrWidth'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_wait_state_adapter.sv
// Fetch wait-state adapter: sits between the core instruction-fetch port and
// an always-granting RAM port, adding a programmable grant latency and a
// programmable response latency, with a bounded number of outstanding fetches.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   gnt_wait_i                   : cycles a request is held before grant (live)
//   rsp_wait_i                   : extra cycles added to each response (live)
//   host_req_i/host_gnt_o        : core fetch handshake, grant is combinational
//   host_addr_i                  : fetch address, forwarded on the grant cycle
//   host_rvalid_o/rdata_o/err_o  : in-order responses, zero when not valid
//   dev_req_o/dev_addr_o         : request to RAM, addr zero when no request
//   dev_rvalid_i/rdata_i/err_i   : RAM response, one cycle after dev_req_o
//
// state | meaning
// IDLE  | no request being delayed; zero-wait requests grant here directly
// WAIT  | counting grant latency for the current request
// STALL | latency elapsed, waiting for an outstanding slot to free up
module fetch_wait_state_adapter
    import fetch_wait_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = RspDataWidth,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned WaitWidth      = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WaitWidth-1:0] gnt_wait_i,
    input  logic [WaitWidth-1:0] rsp_wait_i,
    input  logic                 host_req_i,
    output logic                 host_gnt_o,
    input  logic [AddrWidth-1:0] host_addr_i,
    output logic                 host_rvalid_o,
    output logic [DataWidth-1:0] host_rdata_o,
    output logic                 host_err_o,
    output logic                 dev_req_o,
    output logic [AddrWidth-1:0] dev_addr_o,
    input  logic                 dev_rvalid_i,
    input  logic [DataWidth-1:0] dev_rdata_i,
    input  logic                 dev_err_i
);

    localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);

    fetch_state_e         state_q, state_d;
    logic [WaitWidth-1:0] cnt_q, cnt_d;
    logic [OutWidth-1:0]  outst_q, outst_d;
    stamp_t               stamp_q, stamp_d;
    logic                 dev_pending_q, dev_pending_d;

    rsp_entry_t fifo_head;
    rsp_entry_t fifo_push_entry;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop_en;
    logic       has_space;
    logic       grant;
    stamp_t     rsp_wait_ext;

    // Response release. The pop frees a slot in the same cycle, so a stalled
    // request can be granted alongside the response that makes room for it.
    always_comb begin
        rsp_wait_ext = StampWidth'(rsp_wait_i);
        pop_en       = !rst_i && !fifo_empty
                       && (stamp_age(stamp_q, fifo_head.stamp) > rsp_wait_ext);
        has_space    = (outst_q < OutWidth'(MaxOutstanding)) || pop_en;
    end

    // Only a response to our own previous-cycle request is queued; anything
    // else (e.g. a response to a request issued before reset) is dropped.
    always_comb begin
        fifo_push             = dev_pending_q && dev_rvalid_i;
        fifo_push_entry       = '0;
        fifo_push_entry.rdata = RspDataWidth'(dev_rdata_i);
        fifo_push_entry.err   = dev_err_i;
        fifo_push_entry.stamp = stamp_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req_i) begin
                    if (gnt_wait_i == '0) begin
                        if (has_space) begin
                            grant = 1'b1;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WaitWidth'(1);
                    end
                end
            end
            WAIT: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= gnt_wait_i) begin
                    if (has_space) begin
                        grant = 1'b1;
                    end else begin
                        state_d = STALL;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + WaitWidth'(1);
                end
            end
            STALL: begin
                if (!host_req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (has_space) begin
                    grant = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // A back-to-back request restarts its latency count from IDLE.
        if (grant) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        // Outputs are held quiet in the reset cycle itself.
        if (rst_i) begin
            grant = 1'b0;
        end
    end

    always_comb begin
        stamp_d       = stamp_q + StampWidth'(1);
        dev_pending_d = grant;
        case ({grant, pop_en})
            2'b10:   outst_d = outst_q + OutWidth'(1);
            2'b01:   outst_d = outst_q - OutWidth'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            outst_q       <= '0;
            stamp_q       <= '0;
            dev_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outst_q       <= outst_d;
            stamp_q       <= stamp_d;
            dev_pending_q <= dev_pending_d;
        end
    end

    rsp_stamp_fifo #(
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (fifo_push),
        .push_entry_i (fifo_push_entry),
        .pop_i        (pop_en),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    always_comb begin
        host_gnt_o    = grant;
        dev_req_o     = grant;
        dev_addr_o    = grant ? host_addr_i : '0;
        host_rvalid_o = pop_en;
        host_rdata_o  = pop_en ? DataWidth'(fifo_head.rdata) : '0;
        host_err_o    = pop_en ? fifo_head.err : 1'b0;
    end

    // The outstanding limit keeps the queue from ever being pushed while full.
    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(fifo_push && fifo_full && !pop_en));

endmodule

// File: tb/tb_fetch_wait_state_adapter.sv
module tb_fetch_wait_state_adapter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int WW   = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [WW-1:0] gnt_wait_i = '0;
    logic [WW-1:0] rsp_wait_i = '0;
    logic          host_req_i = 1'b0;
    logic          host_gnt_o;
    logic [AW-1:0] host_addr_i = '0;
    logic          host_rvalid_o;
    logic [DW-1:0] host_rdata_o;
    logic          host_err_o;
    logic          dev_req_o;
    logic [AW-1:0] dev_addr_o;
    logic          dev_rvalid_i = 1'b0;
    logic [DW-1:0] dev_rdata_i = '0;
    logic          dev_err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    fetch_wait_state_adapter #(
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MAXO),
        .WaitWidth      (WW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .gnt_wait_i    (gnt_wait_i),
        .rsp_wait_i    (rsp_wait_i),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_addr_o    (dev_addr_o),
        .dev_rvalid_i  (dev_rvalid_i),
        .dev_rdata_i   (dev_rdata_i),
        .dev_err_i     (dev_err_i)
    );

    // Reference model: responses queued with the absolute cycle they arrived.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          t;
    } exp_rsp_t;

    exp_rsp_t exp_q[$];
    int       cyc = 0;
    int       age = 0;       // cycles the current request has been waiting
    int       out_cnt = 0;   // granted but not yet returned to the host
    bit       prev_gnt = 0;

    int compared = 0;
    int mismatched = 0;

    // Stimulus state applied at the start of each cycle.
    bit          req = 0;
    logic [31:0] addr = '0;
    bit          rst = 1;
    int          gw = 0;
    int          rw = 0;
    bit          spur_en = 0;
    bit          force_spur = 0;

    // RAM emulation
    bit          ram_fire = 0;
    logic [31:0] ram_data = '0;
    logic        ram_err = 1'b0;
    logic [31:0] data_script[$];
    logic        err_script[$];

    // Observations for the hand-computed checks.
    int          t0 = 0;
    int          gnt_log[$];
    int          rv_log[$];
    logic [31:0] rv_data[$];
    logic        rv_err[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int gnt_rel(int i);
        return (gnt_log.size() > i) ? gnt_log[i] - t0 : -1;
    endfunction

    function automatic int rv_rel(int i);
        return (rv_log.size() > i) ? rv_log[i] - t0 : -1;
    endfunction

    function automatic logic [31:0] rv_dat(int i);
        return (rv_data.size() > i) ? rv_data[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic rv_er(int i);
        return (rv_err.size() > i) ? rv_err[i] : 1'bx;
    endfunction

    task automatic clear_logs();
        gnt_log.delete();
        rv_log.delete();
        rv_data.delete();
        rv_err.delete();
        data_script.delete();
        err_script.delete();
    endtask

    task automatic model_and_check();
        bit exp_pop;
        bit space;
        bit exp_gnt;
        exp_pop = !rst && (exp_q.size() > 0) && ((cyc - exp_q[0].t) > rw);
        space   = (out_cnt < MAXO) || exp_pop;
        exp_gnt = !rst && req && (age >= gw) && space;

        chk("host_gnt", host_gnt_o, exp_gnt);
        chk("dev_req", dev_req_o, exp_gnt);
        chk("dev_addr", dev_addr_o, exp_gnt ? addr : 32'h0);
        chk("host_rvalid", host_rvalid_o, exp_pop);
        chk("host_rdata", host_rdata_o, exp_pop ? exp_q[0].data : 32'h0);
        chk("host_err", host_err_o, exp_pop ? exp_q[0].err : 1'b0);

        if (host_gnt_o) gnt_log.push_back(cyc);
        if (host_rvalid_o) begin
            rv_log.push_back(cyc);
            rv_data.push_back(host_rdata_o);
            rv_err.push_back(host_err_o);
        end

        ram_fire = dev_req_o;
        if (dev_req_o) begin
            ram_data = (data_script.size() > 0) ? data_script.pop_front() : $urandom;
            ram_err  = (err_script.size() > 0) ? err_script.pop_front() : ($urandom_range(7) == 0);
        end

        if (rst) begin
            exp_q.delete();
            out_cnt  = 0;
            age      = 0;
            prev_gnt = 0;
        end else begin
            if (exp_pop) void'(exp_q.pop_front());
            if (prev_gnt && dev_rvalid_i) exp_q.push_back('{dev_rdata_i, dev_err_i, cyc});
            out_cnt  = out_cnt + int'(exp_gnt) - int'(exp_pop);
            age      = (exp_gnt || !req) ? 0 : age + 1;
            prev_gnt = exp_gnt;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i       = rst;
        host_req_i  = req;
        host_addr_i = addr;
        gnt_wait_i  = WW'(gw);
        rsp_wait_i  = WW'(rw);
        if (ram_fire) begin
            dev_rvalid_i = 1'b1;
            dev_rdata_i  = ram_data;
            dev_err_i    = ram_err;
        end else begin
            dev_rvalid_i = force_spur || (spur_en && ($urandom_range(15) == 0));
            dev_rdata_i  = $urandom;
            dev_err_i    = $urandom_range(1) == 1;
        end
        force_spur = 0;
        @(negedge clk_i);
        model_and_check();
    endtask

    task automatic idle(input int n);
        req = 0;
        repeat (n) run_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit last_gnt;

        // Reset state
        rst = 1;
        repeat (3) run_cycle();
        rst = 0;
        idle(3);

        // Zero latency: gnt at T, rvalid at T+2 with RAM data.
        gw = 0; rw = 0;
        idle(2);
        clear_logs();
        data_script.push_back(32'hDEAD_BEEF);
        err_script.push_back(1'b0);
        req = 1; addr = 32'h0000_1000;
        t0 = cyc + 1;
        run_cycle();
        idle(6);
        chk("t1_gnt_count", gnt_log.size(), 1);
        chk("t1_gnt_cycle", gnt_rel(0), 0);
        chk("t1_rvalid_cycle", rv_rel(0), 2);
        chk("t1_rdata", rv_dat(0), 32'hDEAD_BEEF);

        // Grant latency 3, response latency 2.
        gw = 3; rw = 2;
        idle(2);
        clear_logs();
        req = 1; addr = 32'h0000_2000;
        t0 = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            if (host_gnt_o) break;
        end
        idle(8);
        chk("t2_gnt_count", gnt_log.size(), 1);
        chk("t2_gnt_cycle", gnt_rel(0), 3);
        chk("t2_rvalid_cycle", rv_rel(0), 7);

        // Request dropped after one cycle of waiting: no grant.
        clear_logs();
        req = 1; addr = 32'h0000_2100;
        t0 = cyc + 1;
        run_cycle();
        idle(8);
        chk("t2_drop_gnt_count", gnt_log.size(), 0);

        // A fresh request afterwards waits the full latency again.
        clear_logs();
        req = 1; addr = 32'h0000_2200;
        t0 = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            run_cycle();
            if (host_gnt_o) break;
        end
        idle(8);
        chk("t2_again_gnt_cycle", gnt_rel(0), 3);

        // Outstanding limit: four grants, stall until first release at +9.
        gw = 0; rw = 7;
        idle(2);
        clear_logs();
        for (int i = 0; i < 8; i++) data_script.push_back(32'hA0 + i);
        req = 1;
        t0 = cyc + 1;
        repeat (13) begin
            addr = 32'h100 + 32'(4 * gnt_log.size());
            run_cycle();
        end
        idle(25);
        chk("t3_gnt_count", gnt_log.size(), 8);
        chk("t3_gnt3_cycle", gnt_rel(3), 3);
        chk("t3_gnt4_cycle", gnt_rel(4), 9);
        chk("t3_rvalid0_cycle", rv_rel(0), 9);
        for (int i = 0; i < 4; i++) chk("t3_rdata_order", rv_dat(i), 32'hA0 + i);

        // rsp_wait 5 -> 0 with three queued: one pop per cycle.
        gw = 0; rw = 5;
        idle(2);
        clear_logs();
        req = 1;
        t0 = cyc + 1;
        repeat (3) begin
            addr = $urandom;
            run_cycle();
        end
        idle(1);
        rw = 0;
        idle(6);
        chk("t4_rvalid_count", rv_log.size(), 3);
        chk("t4_rvalid0", rv_rel(0), 4);
        chk("t4_rvalid1", rv_rel(1), 5);
        chk("t4_rvalid2", rv_rel(2), 6);

        // All slots free again: exactly MAXO grants before the limit bites.
        rw = 15;
        idle(1);
        clear_logs();
        req = 1;
        repeat (6) run_cycle();
        req = 0;
        rw = 0;
        idle(25);
        chk("t4_refill_gnt_count", gnt_log.size(), MAXO);

        // Reset on the cycle after a grant drops the in-flight response.
        gw = 0; rw = 0;
        idle(2);
        clear_logs();
        req = 1; addr = 32'h0000_0500;
        t0 = cyc + 1;
        run_cycle();
        req = 0; rst = 1;
        run_cycle();
        rst = 0; force_spur = 1;
        run_cycle();
        idle(6);
        chk("t5_gnt_count", gnt_log.size(), 1);
        chk("t5_rvalid_count", rv_log.size(), 0);

        // Error flag follows only the second response.
        gw = 0; rw = 1;
        idle(2);
        clear_logs();
        data_script.push_back(32'h11); data_script.push_back(32'h22); data_script.push_back(32'h33);
        err_script.push_back(1'b0); err_script.push_back(1'b1); err_script.push_back(1'b0);
        req = 1;
        repeat (3) run_cycle();
        idle(8);
        chk("t6_rvalid_count", rv_log.size(), 3);
        chk("t6_err0", rv_er(0), 1'b0);
        chk("t6_err1", rv_er(1), 1'b1);
        chk("t6_err2", rv_er(2), 1'b0);
        chk("t6_rdata1", rv_dat(1), 32'h22);
        clear_logs();

        // Randomized traffic against the model.
        spur_en  = 1;
        last_gnt = 0;
        for (int ph = 0; ph < 8; ph++) begin
            req = 0;
            gw  = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(3);
            rw  = $urandom_range(15);
            run_cycle();
            last_gnt = 0;
            for (int n = 0; n < 400; n++) begin
                if (req && last_gnt) begin
                    req  = $urandom_range(1) == 1;
                    addr = $urandom;
                end else if (req) begin
                    if ($urandom_range(15) == 0) req = 0;
                end else begin
                    req  = $urandom_range(2) == 0;
                    addr = $urandom;
                end
                if ($urandom_range(49) == 0) rw = $urandom_range(15);
                rst = ($urandom_range(249) == 0);
                if (rst) req = 0;
                run_cycle();
                last_gnt = host_gnt_o;
                rst = 0;
            end
        end
        spur_en = 0;
        rw = 0;
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
